// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory stage: FSM states, funct3 access widths,
// error codes and the LOAD/STORE major opcodes used by decode and writeback.
package mem_access_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [2:0] LD  = 3'b011;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LWU = 3'b110;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SD  = 3'b011;
    localparam logic [2:0] SW  = 3'b010;
    localparam logic [2:0] SH  = 3'b001;

    localparam logic [1:0] ERR_OK       = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_WIDTH    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/mem_access_unit_align.sv
// Combinational lane logic: byte enables, store/load lane shifts, width legality
// and natural-alignment check for one access.
module mem_lane_align
    import mem_access_pkg::*;
(
    input  logic        is_load,
    input  logic [2:0]  funct3,
    input  logic [2:0]  addr_lo,
    input  logic [63:0] store_data,
    input  logic [63:0] rdata,
    output logic [7:0]  be,
    output logic [63:0] wdata,
    output logic [63:0] ld_shift,
    output logic        width_ok,
    output logic        aligned
);

    logic [5:0] shamt;

    assign shamt    = {addr_lo, 3'b000};
    assign wdata    = store_data << shamt;
    assign ld_shift = rdata >> shamt;

    always_comb begin
        width_ok = 1'b0;
        aligned  = 1'b0;
        be       = 8'hFF;
        case (funct3)
            LD: begin
                width_ok = 1'b1;
                aligned  = (addr_lo == 3'b000);
                be       = 8'hFF;
            end
            LW, LWU: begin
                width_ok = is_load || (funct3 == SW);
                aligned  = (addr_lo[1:0] == 2'b00);
                be       = 8'h0F << addr_lo;
            end
            LH, LHU: begin
                width_ok = is_load || (funct3 == SH);
                aligned  = (addr_lo[0] == 1'b0);
                be       = 8'h03 << addr_lo;
            end
            default: ;
        endcase
        // loads always fetch the whole doubleword
        if (is_load) be = 8'hFF;
    end

endmodule

// File: rtl/mem_access_unit.sv
// RV64 memory-stage load/store engine: req/ack data-memory port, pipeline stall,
// right-justified load data. Optional bus timeout under MEM_ACCESS_TIMEOUT_EN.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [63:0]       ALUres,
    input  logic [63:0]       store_data,
    output logic              stall,
    output logic [63:0]       ld_data,
    output logic              done,
    output logic [1:0]        err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [63:0]       mem_wdata,
    output logic [7:0]        mem_be,
    input  logic [63:0]       mem_rdata,
    input  logic              mem_ack
);

    state_t      state, state_nxt;
    logic        mem_op, accept, legal, ack_ok, expire;
    logic [2:0]  addr_lo_q, lane_sel;
    logic [7:0]  be_c;
    logic [63:0] wdata_c, ld_shift_c;
    logic        width_ok_c, aligned_c;
    logic        unused_ok;

    // upper address bits are intentionally dropped
    assign unused_ok = &{1'b0, ALUres[63:ADDR_W], TIMEOUT_CYCLES[0]};

    assign mem_op   = in_valid & (MemRead | MemWrite);
    assign lane_sel = (state == IDLE) ? ALUres[2:0] : addr_lo_q;
    assign legal    = width_ok_c & aligned_c;
    assign ack_ok   = mem_req & mem_ack;
    assign done     = (state == DONE);

    mem_lane_align u_align (
        .is_load    (MemRead),
        .funct3     (funct3),
        .addr_lo    (lane_sel),
        .store_data (store_data),
        .rdata      (mem_rdata),
        .be         (be_c),
        .wdata      (wdata_c),
        .ld_shift   (ld_shift_c),
        .width_ok   (width_ok_c),
        .aligned    (aligned_c)
    );

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          cnt <= '0;
        else if (accept)                  cnt <= '0;
        else if (state == REQ && !mem_ack) cnt <= cnt + 1'b1;
    end

    // cnt holds the REQ cycles already spent without ack
    assign expire = (state == REQ) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        stall     = 1'b0;
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall     = 1'b1;
                    accept    = 1'b1;
                    state_nxt = legal ? REQ : DONE;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (ack_ok || expire) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (rst) stall = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            addr_lo_q <= '0;
            ld_data   <= '0;
            err       <= ERR_OK;
        end else if (accept) begin
            if (legal) begin
                mem_req   <= 1'b1;
                mem_we    <= ~MemRead;
                mem_addr  <= {ALUres[ADDR_W-1:3], 3'b000};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
                addr_lo_q <= ALUres[2:0];
            end else begin
                err     <= width_ok_c ? ERR_MISALIGN : ERR_WIDTH;
                ld_data <= '0;
            end
        end else if (state == REQ) begin
            // an ack on the expiry cycle still completes normally
            if (ack_ok) begin
                mem_req <= 1'b0;
                err     <= ERR_OK;
                if (!mem_we) ld_data <= ld_shift_c;
            end else if (expire) begin
                mem_req <= 1'b0;
                err     <= ERR_TIMEOUT;
                ld_data <= '0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed vector table, multi-cycle reset/timeout
// sequences and randomized ops against a behavioural access model.
`timescale 1ns/1ps
module tb_mem_access_unit;
    import mem_access_pkg::*;

    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst, in_valid, MemRead, MemWrite, mem_ack;
    logic [2:0]        funct3;
    logic [63:0]       ALUres, store_data, mem_rdata;
    logic              stall, done, mem_req, mem_we;
    logic [63:0]       ld_data, mem_wdata;
    logic [1:0]        err;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_be;

    int pass_n = 0;
    int total_n = 0;
    logic [63:0] model_ld = '0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .ALUres(ALUres), .store_data(store_data), .stall(stall),
        .ld_data(ld_data), .done(done), .err(err), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    typedef struct {
        logic rd; logic wr; logic [2:0] f3;
        logic [63:0] addr; logic [63:0] sdata; logic [63:0] rdata;
        int ack_dly;
    } op_t;

    typedef struct {
        logic req; logic [ADDR_W-1:0] maddr; logic [7:0] be; logic we;
        logic [63:0] wdata; logic [63:0] ld; logic [1:0] err;
        int stall_n; int lat; logic done; logic done2; logic stable;
    } res_t;

    typedef struct { op_t op; res_t exp; } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_n++;
        if (act === exp) pass_n++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mkv(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] sdata,
                                 input logic [63:0] rdata, input int dly, input logic req,
                                 input logic [31:0] maddr, input logic [7:0] be, input logic we,
                                 input logic [63:0] wdata, input logic [63:0] ld,
                                 input logic [1:0] e, input int stall_n, input int lat);
        vec_t v;
        v.op  = '{rd, wr, f3, addr, sdata, rdata, dly};
        v.exp = '{req, maddr, be, we, wdata, ld, e, stall_n, lat, 1'b1, 1'b0, 1'b1};
        return v;
    endfunction

    // Behavioural model: access size in bytes, lane offset, byte arithmetic.
    function automatic res_t model(input op_t op, input logic [63:0] prev_ld);
        res_t r;
        int size, off;
        logic legal;
        r = '{default: '0};
        r.done = 1'b1; r.stable = 1'b1;
        off = int'(op.addr[2:0]);
        case (op.f3)
            3'b011:         size = 8;
            3'b010, 3'b110: size = 4;
            3'b001, 3'b101: size = 2;
            default:        size = 0;
        endcase
        legal = (size != 0) && (op.rd || (op.f3 != 3'b110 && op.f3 != 3'b101));
        if (!legal || (off % size) != 0) begin
            r.err = legal ? 2'b01 : 2'b10;
            r.stall_n = 1; r.lat = 1; r.ld = '0;
        end else begin
            r.req     = 1'b1;
            r.maddr   = op.addr[31:0] & ~32'h7;
            r.we      = !op.rd;
            r.be      = op.rd ? 8'hFF : 8'(((1 << size) - 1) << off);
            r.wdata   = op.sdata << (8 * off);
            r.ld      = op.rd ? (op.rdata >> (8 * off)) : prev_ld;
            r.stall_n = 2 + op.ack_dly;
            r.lat     = r.stall_n;
        end
        return r;
    endfunction

    // Drives one op from posedge+1 and plays memory; ack after ack_dly REQ cycles.
    task automatic run_op(input op_t op, output res_t o);
        int reqc;
        reqc = 0;
        o = '{default: '0};
        o.stable = 1'b1;
        in_valid = 1'b1; MemRead = op.rd; MemWrite = op.wr; funct3 = op.f3;
        ALUres = op.addr; store_data = op.sdata; mem_rdata = op.rdata; mem_ack = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            #1;
            if (stall) o.stall_n++;
            if (done) begin
                o.done = 1'b1; o.lat = cyc; o.ld = ld_data; o.err = err;
                break;
            end
            if (mem_req) begin
                if (!o.req) begin
                    o.req = 1'b1; o.maddr = mem_addr; o.be = mem_be; o.we = mem_we; o.wdata = mem_wdata;
                end else if ({mem_addr, mem_be, mem_we, mem_wdata} !== {o.maddr, o.be, o.we, o.wdata}) begin
                    o.stable = 1'b0;
                end
                mem_ack = (reqc == op.ack_dly);
                reqc++;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0;
        end
        if (o.done) begin
            @(posedge clk); #1;
            o.done2 = done;
        end
        in_valid = 1'b0;
    endtask

    task automatic compare(input string tag, input res_t a, input res_t e);
        chk({tag, ".done"},    64'(a.done),    64'(e.done));
        chk({tag, ".lat"},     64'(a.lat),     64'(e.lat));
        chk({tag, ".stall_n"}, 64'(a.stall_n), 64'(e.stall_n));
        chk({tag, ".err"},     64'(a.err),     64'(e.err));
        chk({tag, ".req"},     64'(a.req),     64'(e.req));
        chk({tag, ".ld_data"}, a.ld,           e.ld);
        chk({tag, ".pulse"},   64'(a.done2),   64'(e.done2));
        if (e.req) begin
            chk({tag, ".addr"},   64'(a.maddr),  64'(e.maddr));
            chk({tag, ".be"},     64'(a.be),     64'(e.be));
            chk({tag, ".we"},     64'(a.we),     64'(e.we));
            chk({tag, ".stable"}, 64'(a.stable), 64'(e.stable));
            if (e.we) chk({tag, ".wdata"}, a.wdata, e.wdata);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[13];
        res_t        r, e;
        op_t         op;
        logic [2:0]  f3s[5];

        f3s = '{3'b011, 3'b010, 3'b110, 3'b001, 3'b101};
        //            rd    wr    f3      addr                    sdata                   rdata                    dly req maddr         be     we    wdata                   ld                      err    st lat
        tbl[0]  = mkv(1'b1, 1'b0, LD,     64'h100,                64'h0,                  64'h1122334455667788,    1, 1, 32'h100,      8'hFF, 1'b0, 64'h0,                  64'h1122334455667788,   2'b00, 3, 3);
        tbl[1]  = mkv(1'b0, 1'b1, SH,     64'h106,                64'hABCD,               64'h0,                   0, 1, 32'h100,      8'hC0, 1'b1, 64'hABCD000000000000,   64'h1122334455667788,   2'b00, 2, 2);
        tbl[2]  = mkv(1'b1, 1'b0, LW,     64'h104,                64'h0,                  64'hDEADBEEF00000000,    0, 1, 32'h100,      8'hFF, 1'b0, 64'h0,                  64'h00000000DEADBEEF,   2'b00, 2, 2);
        tbl[3]  = mkv(1'b1, 1'b0, LW,     64'h102,                64'h0,                  64'h0,                   0, 0, 32'h0,        8'h00, 1'b0, 64'h0,                  64'h0,                  2'b01, 1, 1);
        tbl[4]  = mkv(1'b0, 1'b1, 3'b110, 64'h200,                64'h55,                 64'h0,                   0, 0, 32'h0,        8'h00, 1'b0, 64'h0,                  64'h0,                  2'b10, 1, 1);
        tbl[5]  = mkv(1'b1, 1'b1, 3'b110, 64'h200,                64'h55,                 64'h0123456789ABCDEF,    2, 1, 32'h200,      8'hFF, 1'b0, 64'h0,                  64'h0123456789ABCDEF,   2'b00, 4, 4);
        tbl[6]  = mkv(1'b1, 1'b0, LHU,    64'h10F,                64'h0,                  64'h0,                   0, 0, 32'h0,        8'h00, 1'b0, 64'h0,                  64'h0,                  2'b01, 1, 1);
        tbl[7]  = mkv(1'b0, 1'b1, SD,     64'h10C,                64'h1,                  64'h0,                   0, 0, 32'h0,        8'h00, 1'b0, 64'h0,                  64'h0,                  2'b01, 1, 1);
        tbl[8]  = mkv(1'b0, 1'b1, SW,     64'h10C,                64'hCAFEF00D,           64'h0,                   1, 1, 32'h108,      8'hF0, 1'b1, 64'hCAFEF00D00000000,   64'h0,                  2'b00, 3, 3);
        tbl[9]  = mkv(1'b1, 1'b0, LH,     64'hFFFFFFFF00000206,   64'h0,                  64'hBEEF000000000000,    0, 1, 32'h200,      8'hFF, 1'b0, 64'h0,                  64'h000000000000BEEF,   2'b00, 2, 2);
        tbl[10] = mkv(1'b0, 1'b1, SD,     64'h0000000100000018,   64'h0123456789ABCDEF,   64'h0,                   0, 1, 32'h18,       8'hFF, 1'b1, 64'h0123456789ABCDEF,   64'h000000000000BEEF,   2'b00, 2, 2);
        tbl[11] = mkv(1'b1, 1'b0, 3'b000, 64'h0,                  64'h0,                  64'h0,                   0, 0, 32'h0,        8'h00, 1'b0, 64'h0,                  64'h0,                  2'b10, 1, 1);
        tbl[12] = mkv(1'b0, 1'b1, 3'b111, 64'h101,                64'h0,                  64'h0,                   0, 0, 32'h0,        8'h00, 1'b0, 64'h0,                  64'h0,                  2'b10, 1, 1);

        // Reset with a load presented: nothing may stall or request.
        rst = 1'b1; in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = LD;
        ALUres = 64'h100; store_data = '0; mem_rdata = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.stall",   64'(stall),   64'h0);
        chk("reset.req",     64'(mem_req), 64'h0);
        chk("reset.done",    64'(done),    64'h0);
        chk("reset.err",     64'(err),     64'h0);
        chk("reset.ld_data", ld_data,      64'h0);
        chk("reset.fields",  {mem_wdata[31:0], mem_addr[23:0], mem_be}, 64'h0);
        chk("reset.we",      64'(mem_we),  64'h0);
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            run_op(tbl[i].op, r);
            compare($sformatf("vec%0d", i), r, tbl[i].exp);
            model_ld = tbl[i].exp.ld;
        end

        // Randomized ops with idle gaps and stray acks in between.
        for (int i = 0; i < 40; i++) begin
            op.rd    = 1'($urandom_range(0, 1));
            op.wr    = op.rd ? 1'($urandom_range(0, 1)) : 1'b1;
            op.f3    = ($urandom_range(0, 9) < 8) ? f3s[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
            op.addr  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) op.addr[1:0] = 2'b00;
            op.sdata = {$urandom, $urandom};
            op.rdata = {$urandom, $urandom};
            op.ack_dly = int'($urandom_range(0, 3));
            e = model(op, model_ld);
            run_op(op, r);
            compare($sformatf("rnd%0d", i), r, e);
            model_ld = e.ld;
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'($urandom_range(0, 1)); MemRead = 1'b0; MemWrite = 1'b0; mem_ack = 1'b1;
                @(posedge clk); #1;
                chk($sformatf("idle%0d.stall", i), 64'(stall), 64'h0);
                chk($sformatf("idle%0d.req", i), 64'(mem_req | done), 64'h0);
                chk($sformatf("idle%0d.ld_hold", i), ld_data, model_ld);
                mem_ack = 1'b0; in_valid = 1'b0;
            end
        end

        // Asynchronous reset in the middle of an outstanding request.
        in_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; funct3 = LD; ALUres = 64'h300; mem_ack = 1'b0;
        @(posedge clk); #1;
        chk("rstmid.pre_req", 64'(mem_req), 64'h1);
        #2 rst = 1'b1;
        #1;
        chk("rstmid.req",   64'(mem_req), 64'h0);
        chk("rstmid.stall", 64'(stall),   64'h0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("rstmid.idle_stall", 64'(stall), 64'h0);
        @(posedge clk); #1;
        chk("rstmid.idle_req", 64'(mem_req | done), 64'h0);
        model_ld = '0;
        op = '{1'b1, 1'b0, LW, 64'h404, 64'h0, 64'h76543210_00000000, 0};
        e = model(op, model_ld);
        run_op(op, r);
        compare("post_rst", r, e);

`ifdef MEM_ACCESS_TIMEOUT_EN
        // No ack ever: four REQ cycles then err=11.
        op = '{1'b1, 1'b0, LD, 64'h500, 64'h0, 64'hFFFF, 1000};
        run_op(op, r);
        e = '{1'b1, 32'h500, 8'hFF, 1'b0, 64'h0, 64'h0, 2'b11, 5, 5, 1'b1, 1'b0, 1'b1};
        compare("timeout", r, e);
        // Ack on the expiry cycle completes normally.
        op = '{1'b1, 1'b0, LD, 64'h508, 64'h0, 64'h1234, 3};
        run_op(op, r);
        e = '{1'b1, 32'h508, 8'hFF, 1'b0, 64'h0, 64'h1234, 2'b00, 5, 5, 1'b1, 1'b0, 1'b1};
        compare("ack_at_expiry", r, e);
`endif

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

endmodule
